// File: rtl/cpu_state_uart_tx_if.sv
// cpu_state_uart_tx_if
// Bundles the CPU-state tap and the serial-side status signals of the
// cpu_state_uart_tx debug readout block.
//   snap            capture strobe, one pulse per CPU step
//   r0view..r3view  CPU register views
//   zfview, cfview  CPU zero / carry flags
//   tx              UART serial line (idles high)
//   busy            packet in flight
//   done            one-cycle pulse when the last stop bit ends
//   drop_cnt        saturating count of snaps rejected while busy
// master: the side that drives the CPU state (step logic / bench).
// slave : the UART transmitter.
interface cpu_state_uart_tx_if;
    logic       snap;
    logic [7:0] r0view;
    logic [7:0] r1view;
    logic [7:0] r2view;
    logic [7:0] r3view;
    logic       zfview;
    logic       cfview;
    logic       tx;
    logic       busy;
    logic       done;
    logic [7:0] drop_cnt;

    modport master (
        output snap, r0view, r1view, r2view, r3view, zfview, cfview,
        input  tx, busy, done, drop_cnt
    );

    modport slave (
        input  snap, r0view, r1view, r2view, r3view, zfview, cfview,
        output tx, busy, done, drop_cnt
    );
endinterface

// File: rtl/cpu_state_uart_tx.sv
// cpu_state_uart_tx
// On each snap strobe (while idle) snapshots r0..r3, zf and cf, frames them
// as the 7-byte packet A5, r0, r1, r2, r3, FLAGS, CSUM and shifts it out as
// back-to-back 8N1 UART bytes, LSB first.
//   FLAGS = {6'b0, zf, cf}
//   CSUM  = r0 ^ r1 ^ r2 ^ r3 ^ FLAGS   (header not included)
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    cpu_state_uart_tx_if.slave: snap, r*view, zfview, cfview in;
//          tx, busy, done, drop_cnt out
// Parameters:
//   CLK_FREQ, BAUD  -> CLKS_PER_BIT = CLK_FREQ/BAUD, must be >= 2
module cpu_state_uart_tx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cpu_state_uart_tx_if.slave   bus
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [7:0]       HEADER    = 8'hA5;
    localparam int               NUM_BYTES = 7;

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("cpu_state_uart_tx: CLK_FREQ/BAUD must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t           state_reg,    state_next;
    logic [CNT_W-1:0] baud_cnt_reg, baud_cnt_next;
    logic [2:0]       bit_idx_reg,  bit_idx_next;
    logic [2:0]       byte_idx_reg, byte_idx_next;

    logic [NUM_BYTES-1:0][7:0] pkt_reg;
    logic [NUM_BYTES-1:0][7:0] cap_byte;
    logic [3:0][7:0]           reg_view;
    logic [7:0]                flags;

    logic       done_reg;
    logic [7:0] drop_cnt_reg;

    logic       bit_end;
    logic       last_byte;
    logic       accept;
    logic       drop;
    logic [7:0] cur_byte;
    logic       tx_out;
    logic       busy_out;

    // ------------------------------------------------------------------
    // Packet assembly from the live inputs; only latched on accept, so
    // anything the CPU does after the strobe cannot leak into the packet.
    // ------------------------------------------------------------------
    assign reg_view[0] = bus.r0view;
    assign reg_view[1] = bus.r1view;
    assign reg_view[2] = bus.r2view;
    assign reg_view[3] = bus.r3view;
    assign flags       = {6'b0, bus.zfview, bus.cfview};

    assign cap_byte[0] = HEADER;
    for (genvar gi = 0; gi < 4; gi++) begin : g_reg_bytes
        assign cap_byte[gi+1] = reg_view[gi];
    end
    assign cap_byte[5] = flags;
    assign cap_byte[6] = reg_view[0] ^ reg_view[1] ^ reg_view[2] ^ reg_view[3] ^ flags;

    // ------------------------------------------------------------------
    // Shared decode
    // ------------------------------------------------------------------
    assign bit_end   = (baud_cnt_reg == BAUD_LAST);
    assign last_byte = (byte_idx_reg == 3'(NUM_BYTES - 1));
    // The done cycle is already IDLE, so a snap there is accepted rather
    // than dropped; that is what lets packets run back to back.
    assign accept    = bus.snap && (state_reg == S_IDLE);
    assign drop      = bus.snap && (state_reg != S_IDLE);
    assign cur_byte  = pkt_reg[byte_idx_reg];

    // ------------------------------------------------------------------
    // FSM state register (plus the counters it owns)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            byte_idx_reg <= '0;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_idx_reg  <= bit_idx_next;
            byte_idx_reg <= byte_idx_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg;
        bit_idx_next  = bit_idx_reg;
        byte_idx_next = byte_idx_reg;

        case (state_reg)
            S_IDLE: begin
                if (bus.snap) begin
                    state_next    = S_START;
                    baud_cnt_next = '0;
                    bit_idx_next  = '0;
                    byte_idx_next = '0;
                end
            end

            S_START: begin
                if (bit_end) begin
                    state_next    = S_DATA;
                    baud_cnt_next = '0;
                    bit_idx_next  = '0;
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = S_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    if (last_byte) begin
                        state_next = S_IDLE;
                    end else begin
                        // Next start bit follows immediately, no idle gap.
                        state_next    = S_START;
                        byte_idx_next = byte_idx_reg + 3'd1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs. tx is decoded from registered state only, so it goes
    // high the instant rst_n drops without needing a clock.
    // ------------------------------------------------------------------
    always_comb begin
        tx_out   = 1'b1;
        busy_out = 1'b1;
        case (state_reg)
            S_IDLE:  begin tx_out = 1'b1; busy_out = 1'b0; end
            S_START: tx_out = 1'b0;
            S_DATA:  tx_out = cur_byte[bit_idx_reg];
            S_STOP:  tx_out = 1'b1;
            default: begin tx_out = 1'b1; busy_out = 1'b0; end
        endcase
    end

    // ------------------------------------------------------------------
    // Snapshot register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_reg <= '0;
        end else if (accept) begin
            pkt_reg <= cap_byte;
        end
    end

    // ------------------------------------------------------------------
    // done pulse: registered on the edge that ends the final stop bit, so
    // it appears in the same cycle busy first reads low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_reg <= 1'b0;
        end else begin
            done_reg <= (state_reg == S_STOP) && bit_end && last_byte;
        end
    end

    // ------------------------------------------------------------------
    // Overrun counter, saturating at 255, cleared only by reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_reg <= '0;
        end else if (drop && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end

    assign bus.tx       = tx_out;
    assign bus.busy     = busy_out;
    assign bus.done     = done_reg;
    assign bus.drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_cpu_state_uart_tx.sv
// tb_cpu_state_uart_tx
// Two instances: a fast one (CLK_FREQ=16, BAUD=4 -> 4 clocks/bit) that is
// checked every cycle against a packet-timeline model plus a UART decoder,
// and a default-parameter one used for drop counter saturation.
module tb_cpu_state_uart_tx;

    localparam int CPB   = 4;
    localparam int TOTAL = 70 * CPB;

    logic clk    = 1'b0;
    logic clk_en = 1'b0;
    logic rst_n_a = 1'b0;
    logic rst_n_b = 1'b0;

    int checks = 0;
    int errors = 0;

    cpu_state_uart_tx_if ia();
    cpu_state_uart_tx_if ib();

    cpu_state_uart_tx #(.CLK_FREQ(16), .BAUD(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .bus   (ia)
    );

    cpu_state_uart_tx dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .bus   (ib)
    );

    initial begin
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A packet is just a 70-bit line pattern; the line shows bit pos/CPB
    // during cycle pos after the accepting edge.
    function automatic logic [69:0] build_bits(input logic [7:0] a, input logic [7:0] b,
                                               input logic [7:0] c, input logic [7:0] d,
                                               input logic z, input logic cy);
        logic [7:0] pkt [7];
        logic [69:0] v;
        pkt[0] = 8'hA5; pkt[1] = a; pkt[2] = b; pkt[3] = c; pkt[4] = d;
        pkt[5] = {6'b0, z, cy};
        pkt[6] = a ^ b ^ c ^ d ^ pkt[5];
        v = '0;
        for (int k = 0; k < 7; k++) begin
            v[k*10] = 1'b0;
            for (int j = 0; j < 8; j++) v[k*10+1+j] = pkt[k][j];
            v[k*10+9] = 1'b1;
        end
        return v;
    endfunction

    int          m_pos   = -1;
    int          m_drops = 0;
    logic        m_done  = 1'b0;
    logic [69:0] m_bits  = '1;

    always @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            m_pos   <= -1;
            m_drops <= 0;
            m_done  <= 1'b0;
        end else begin
            m_done <= (m_pos == TOTAL - 1);
            if (m_pos == -1) begin
                if (ia.snap) begin
                    m_pos  <= 0;
                    m_bits <= build_bits(ia.r0view, ia.r1view, ia.r2view, ia.r3view,
                                         ia.zfview, ia.cfview);
                end
            end else begin
                if (ia.snap && m_drops < 255) m_drops <= m_drops + 1;
                m_pos <= (m_pos == TOTAL - 1) ? -1 : m_pos + 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic exp_tx;
        forever begin
            @(negedge clk);
            exp_tx = (m_pos == -1) ? 1'b1 : m_bits[m_pos / CPB];
            chk("cycle{tx,busy,done,drop}",
                {21'b0, ia.tx, ia.busy, ia.done, ia.drop_cnt},
                {21'b0, exp_tx, (m_pos != -1), m_done, 8'(m_drops)});
        end
    end

    // ---------------- UART decoder (fixed literal byte checks) ----------------
    logic [7:0] rxq [$];
    initial begin
        bit         active = 0;
        int         t = 0;
        logic [7:0] sh = '0;
        forever begin
            @(negedge clk);
            if (!rst_n_a) begin
                active = 0;
            end else if (!active) begin
                if (ia.tx == 1'b0) begin
                    active = 1;
                    t = 1;
                end
            end else begin
                if (t % CPB == CPB / 2) begin
                    if (t / CPB >= 1 && t / CPB <= 8) begin
                        sh[t / CPB - 1] = ia.tx;
                    end else if (t / CPB == 9) begin
                        chk("stop_bit", {31'b0, ia.tx}, 32'd1);
                        rxq.push_back(sh);
                        active = 0;
                    end
                end
                t++;
            end
        end
    end

    int busy_cycles = 0;
    int done_seen   = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (ia.busy) busy_cycles++;
            if (ia.done) done_seen++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_regs(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic [7:0] d, input logic z, input logic cy);
        ia.r0view = a; ia.r1view = b; ia.r2view = c; ia.r3view = d;
        ia.zfview = z; ia.cfview = cy;
    endtask

    task automatic pulse_snap();
        ia.snap = 1'b1;
        tick();
        ia.snap = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (ia.busy && n < 500) begin
            tick();
            n++;
        end
        chk("idle_reached", {31'b0, ia.busy}, 32'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!ia.done && n < 500) begin
            tick();
            n++;
        end
        chk("done_reached", {31'b0, ia.done}, 32'd1);
    endtask

    task automatic expect_packet(input string name, input logic [55:0] exp);
        logic [7:0] b;
        for (int i = 0; i < 7; i++) begin
            if (rxq.size() == 0) begin
                chk($sformatf("%s_byte%0d_missing", name, i), 32'd0, 32'd1);
            end else begin
                b = rxq.pop_front();
                chk($sformatf("%s_byte%0d", name, i), {24'b0, b}, {24'b0, exp[55-8*i -: 8]});
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        ia.snap = 1'b0;
        set_regs(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        ib.snap = 1'b0;
        ib.r0view = 8'h11; ib.r1view = 8'h22; ib.r2view = 8'h33; ib.r3view = 8'h44;
        ib.zfview = 1'b0; ib.cfview = 1'b1;

        // Reset held with the clock stopped.
        #20;
        chk("rst_tx",       {31'b0, ia.tx},   32'd1);
        chk("rst_busy",     {31'b0, ia.busy}, 32'd0);
        chk("rst_done",     {31'b0, ia.done}, 32'd0);
        chk("rst_drop_cnt", {24'b0, ia.drop_cnt}, 32'd0);
        chk("rst_b_tx",     {31'b0, ib.tx},   32'd1);

        clk_en = 1'b1;
        repeat (3) tick();
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        repeat (20) tick();
        chk("idle_tx_high", {31'b0, ia.tx}, 32'd1);

        // Basic packet + snapshot isolation.
        set_regs(8'h12, 8'h34, 8'h56, 8'h78, 1'b1, 1'b0);
        busy_cycles = 0;
        done_seen   = 0;
        pulse_snap();
        set_regs(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1);
        chk("latency_tx_low", {31'b0, ia.tx}, 32'd0);
        chk("latency_busy",   {31'b0, ia.busy}, 32'd1);
        wait_idle();
        tick();
        chk("busy_cycles", busy_cycles, 32'd280);
        chk("done_pulses", done_seen, 32'd1);
        expect_packet("basic", 56'hA5_12_34_56_78_02_0A);

        // Overrun during a packet, then a back-to-back packet from the done cycle.
        repeat (5) tick();
        set_regs(8'h12, 8'h34, 8'h56, 8'h78, 1'b1, 1'b0);
        pulse_snap();
        repeat (50) tick();
        pulse_snap();
        repeat (50) tick();
        pulse_snap();
        repeat (50) tick();
        pulse_snap();
        chk("drop_cnt_3", {24'b0, ia.drop_cnt}, 32'd3);
        wait_done();
        set_regs(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        pulse_snap();
        chk("b2b_tx_low", {31'b0, ia.tx}, 32'd0);
        expect_packet("overrun", 56'hA5_12_34_56_78_02_0A);
        wait_idle();
        tick();
        expect_packet("b2b", 56'hA5_00_00_00_00_01_01);
        chk("drop_cnt_keep", {24'b0, ia.drop_cnt}, 32'd3);

        // Reset during data bit 3 of the r1 byte (line cycles 56..59).
        repeat (5) tick();
        set_regs(8'h12, 8'h34, 8'h56, 8'h78, 1'b1, 1'b0);
        pulse_snap();
        repeat (56) tick();
        #2;
        rst_n_a = 1'b0;
        #1;
        chk("midrst_tx",   {31'b0, ia.tx},   32'd1);
        chk("midrst_busy", {31'b0, ia.busy}, 32'd0);
        chk("midrst_drop", {24'b0, ia.drop_cnt}, 32'd0);
        repeat (2) tick();
        rst_n_a = 1'b1;
        rxq.delete();
        repeat (5) tick();
        chk("post_rst_tx", {31'b0, ia.tx}, 32'd1);
        set_regs(8'h81, 8'h00, 8'hFF, 8'h3C, 1'b1, 1'b1);
        pulse_snap();
        wait_idle();
        tick();
        expect_packet("post_rst", 56'hA5_81_00_FF_3C_03_41);

        // Saturation on the default-parameter instance.
        ib.snap = 1'b1;
        tick();
        chk("sat_busy_start", {31'b0, ib.busy}, 32'd1);
        repeat (100) tick();
        chk("sat_drop_100", {24'b0, ib.drop_cnt}, 32'd100);
        repeat (200) tick();
        ib.snap = 1'b0;
        chk("sat_drop_255", {24'b0, ib.drop_cnt}, 32'd255);
        chk("sat_busy_end", {31'b0, ib.busy}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_state_uart_tx.md
Name: cpu_state_uart_tx

Overview:
Debug readout path for the trainer CPU: the step logic drives the CPU forward, and this block reports CPU state back to the host. On each step strobe it snapshots r0..r3, zf and cf, frames them into a 7-byte packet, and shifts the packet out as 8N1 UART on a single pin. It sits beside mojo_top, taps the register-view and flag outputs, and drives the board's serial TX line.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz.
BAUD, 115200, UART bit rate.
CLKS_PER_BIT, CLK_FREQ/BAUD (integer division), clocks per UART bit. Must be >= 2; elaboration-time error otherwise.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
snap  input  1  single-cycle capture strobe, pulsed once per CPU step.
r0view  input  8  CPU register r0.
r1view  input  8  CPU register r1.
r2view  input  8  CPU register r2.
r3view  input  8  CPU register r3.
zfview  input  1  CPU zero flag.
cfview  input  1  CPU carry flag.
tx  output  1  UART serial out; idles high.
busy  output  1  high while a packet is in flight.
done  output  1  one-cycle pulse when the final stop bit ends.
drop_cnt  output  8  saturating count of snaps rejected while busy.

Behaviour:
- Interface (decided): one clock; reset is asynchronous and active-low.
- Reset values, effective immediately on rst_n low with no clock needed: tx=1, busy=0, done=0, drop_cnt=0, FSM=IDLE, all counters 0. A reset mid-packet abandons the packet and tx returns high at once.
- Packet: 0xA5, r0, r1, r2, r3, FLAGS, CSUM.
  - FLAGS = {6'b0, zf, cf}.
  - CSUM = r0^r1^r2^r3^FLAGS. The header is excluded from the checksum.
- Byte frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit is held exactly CLKS_PER_BIT cycles. There is no idle gap between bytes.
- Capture: snap=1 in IDLE at edge N latches all inputs into a snapshot register. Later input changes do not affect the packet in flight.
- Start timing after the edge-N capture:
  - busy=1 and tx=0 (header start bit) from edge N onward, so they are visible in cycle N+1.
  - Latency from snap to tx falling is 1 clock.
- FSM states and transitions:
  - IDLE -> START on snap.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START with the next byte if byte_idx<6.
  - STOP -> IDLE if byte_idx==6.
- Baud counter runs 0..CLKS_PER_BIT-1. A bit completes at terminal count. bit_idx and byte_idx reset on packet start.
- Total packet length: 70*CLKS_PER_BIT cycles from tx falling to the end of the last stop bit.
- Completion, on the edge that ends the last stop bit:
  - done=1 for exactly one cycle, busy=0 and FSM=IDLE on that same edge.
  - A snap present in the done cycle is accepted, so back-to-back packets have zero idle gap.
- Overrun: snap=1 while busy=1 is ignored and drop_cnt increments. drop_cnt saturates at 255 and clears only on reset.
- snap held high for several cycles in IDLE starts exactly one packet. The remaining high cycles fall during busy and each one counts as a drop.

Test Plan:
- Reset: hold rst_n=0 with the clock stopped -> tx=1, busy=0, done=0, drop_cnt=0. Release -> tx stays 1 indefinitely with snap=0.
- Basic packet: CLK_FREQ=16, BAUD=4 (CLKS_PER_BIT=4); r0=0x12, r1=0x34, r2=0x56, r3=0x78, zf=1, cf=0; one-cycle snap.
  - Decoded bytes must be A5 12 34 56 78 02 0A.
  - tx falls 1 clock after snap; each bit lasts 4 clocks; busy high for 280 clocks.
  - done pulses once when busy falls.
- Snapshot isolation: change all register inputs to 0xFF one cycle after snap -> packet still reads A5 12 34 56 78 02 0A.
- Overrun and back-to-back:
  - Pulse snap 3 times mid-packet -> drop_cnt=3 and the packet is unaffected.
  - Pulse snap in the done cycle with r0..r3=0, zf=0, cf=1 -> immediate second packet A5 00 00 00 00 01 01 with no idle high bit between packets.
- Saturation: issue 300 snaps during one long packet (default parameters) -> drop_cnt=255.
- Reset mid-packet: assert rst_n low during data bit 3 of byte r1 -> tx=1 and busy=0 asynchronously. After release, the next snap sends a complete, correct packet.
